mips32_boot_ctrl: RTL and testbench

//  Synthesisable boot/run/dump sequencer for the pipelined MIPS32 core. Streams a program

---
 rtl/mips32_boot_ctrl_pkg.sv | 17 +
 rtl/mips32_boot_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mips32_boot_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips32_boot_ctrl_pkg.sv
// Shared types and constants for the MIPS32 boot/run/dump sequencer.
package mips32_boot_pkg;
    localparam int         DATA_W = 32;
    localparam logic [5:0] OP_HLT = 6'h3f;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_REGINIT,
        S_CLEAR,
        S_RUN,
        S_DUMP_REQ,
        S_DUMP_CAP,
        S_DUMP_OUT,
        S_DONE
    } state_t;
endpackage

// File: rtl/mips32_boot_ctrl.sv
// Boot sequencer: loads program memory, initialises the register file, runs the core
// until HLT or timeout, then streams a memory window out with back-pressure.
module mips32_boot_ctrl
    import mips32_boot_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int NUM_REGS     = 32,
    parameter int REG_INIT_IDX = 1,
    parameter int TIMEOUT_CYC  = 1024,
    localparam int RIDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] load_len_i,
    input  logic [ADDR_W-1:0] dump_base_i,
    input  logic [ADDR_W-1:0] dump_len_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              reg_we_o,
    output logic [RIDX_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic              core_pc_clr_o,
    output logic              core_run_o,
    input  logic              core_halted_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timed_out_o
);

    state_t              state_q, state_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]   load_len_q, load_len_d;
    logic [ADDR_W-1:0]   dump_base_q, dump_base_d;
    logic [ADDR_W-1:0]   dump_len_q, dump_len_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                timed_out_q, timed_out_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            load_len_q  <= '0;
            dump_base_q <= '0;
            dump_len_q  <= '0;
            out_data_q  <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_len_q  <= load_len_d;
            dump_base_q <= dump_base_d;
            dump_len_q  <= dump_len_d;
            out_data_q  <= out_data_d;
            timed_out_q <= timed_out_d;
        end
    end

    // One shared counter: load index, register index, run cycles, dump index.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        load_len_d    = load_len_q;
        dump_base_d   = dump_base_q;
        dump_len_d    = dump_len_q;
        out_data_d    = out_data_q;
        timed_out_d   = timed_out_q;
        in_ready_o    = 1'b0;
        mem_we_o      = 1'b0;
        mem_re_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        reg_we_o      = 1'b0;
        reg_addr_o    = '0;
        reg_wdata_o   = '0;
        core_pc_clr_o = 1'b0;
        core_run_o    = 1'b0;
        out_valid_o   = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    load_len_d  = load_len_i;
                    dump_base_d = dump_base_i;
                    dump_len_d  = dump_len_i;
                    timed_out_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = (load_len_i == '0) ? S_REGINIT : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    mem_we_o    = 1'b1;
                    mem_addr_o  = cnt_q[ADDR_W-1:0];
                    mem_wdata_o = in_data_i;
                    if (cnt_q == 32'(load_len_q) - 32'd1) begin
                        cnt_d   = '0;
                        state_d = S_REGINIT;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            S_REGINIT: begin
                reg_we_o    = 1'b1;
                reg_addr_o  = cnt_q[RIDX_W-1:0];
                reg_wdata_o = (REG_INIT_IDX != 0) ? cnt_q : '0;
                if (cnt_q == 32'(NUM_REGS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_CLEAR: begin
                core_pc_clr_o = 1'b1;
                cnt_d         = '0;
                state_d       = S_RUN;
            end
            S_RUN: begin
                core_run_o = 1'b1;
                // A halt in the same cycle as the timeout counts as a clean halt.
                if (core_halted_i ||
                    (TIMEOUT_CYC != 0 && cnt_q == 32'(TIMEOUT_CYC - 1))) begin
                    timed_out_d = !core_halted_i;
                    cnt_d       = '0;
                    state_d     = (dump_len_q == '0) ? S_DONE : S_DUMP_REQ;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DUMP_REQ: begin
                mem_re_o   = 1'b1;
                mem_addr_o = dump_base_q + cnt_q[ADDR_W-1:0];
                state_d    = S_DUMP_CAP;
            end
            S_DUMP_CAP: begin
                out_data_d = mem_rdata_i;
                state_d    = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    if (cnt_q == 32'(dump_len_q) - 32'd1) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 32'd1;
                        state_d = S_DUMP_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_data_o  = out_data_q;
    assign done_o      = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign timed_out_o = timed_out_q && (state_q == S_DONE);

endmodule

// File: tb/tb_mips32_boot_ctrl.sv
// Bench for mips32_boot_ctrl: behavioural memory, register file and a tiny ISA-level
// core model that runs the loaded program when the core is released.
module tb_mips32_boot_ctrl;
    localparam int AW = 10;
    localparam int NR = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [AW-1:0] load_len = '0, dump_base = '0, dump_len = '0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = '0;
    logic          out_ready = 1'b1;
    logic          in_ready, mem_we, mem_re, reg_we, core_pc_clr, core_run, core_halted;
    logic          out_valid, busy, done, timed_out;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata, reg_wdata, out_data;
    logic [4:0]    reg_addr;

    mips32_boot_ctrl #(.ADDR_W(AW), .NUM_REGS(NR), .REG_INIT_IDX(1), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .load_len_i(load_len),
        .dump_base_i(dump_base), .dump_len_i(dump_len), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_ready_o(in_ready), .mem_we_o(mem_we), .mem_re_o(mem_re),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .reg_we_o(reg_we), .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata),
        .core_pc_clr_o(core_pc_clr), .core_run_o(core_run), .core_halted_i(core_halted),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
        .busy_o(busy), .done_o(done), .timed_out_o(timed_out)
    );

    wire [120:0] all_outs = {in_ready, mem_we, mem_re, mem_addr, mem_wdata, reg_we, reg_addr,
                             reg_wdata, core_pc_clr, core_run, out_valid, out_data, busy, done,
                             timed_out};

    // Environment: memory, register file, core model, monitors.
    logic [31:0] mem  [0:1023];
    logic [31:0] regs [0:NR-1];
    logic [31:0] rdata_q = '0;
    int          run_cyc = 0;
    bit          halt_en = 1'b0, exec_en = 1'b0;
    int          halt_n = 0;
    bit          bd_we = 1'b0, bd_clr = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    int n_we = 0, n_rd = 0, n_out = 0, n_regwe = 0, n_run = 0, n_inrdy = 0, n_outv = 0;
    int n_excl = 0, n_stab = 0;
    logic [9:0]  we_log  [0:255];
    logic [9:0]  rd_log  [0:255];
    logic [31:0] out_log [0:255];
    bit          hold_pend = 1'b0;
    logic [31:0] hold_data = '0;

    assign mem_rdata   = rdata_q;
    assign core_halted = halt_en && (run_cyc >= halt_n);

    // Instruction-level core: ADDI 0a, LW 08, SW 09, OR 03, HLT 3f.
    function automatic void exec_prog();
        int          pc;
        logic [31:0] ir, ea;
        pc = 0;
        for (int s = 0; s < 64; s++) begin
            ir = mem[pc[9:0]];
            pc++;
            ea = regs[ir[25:21]] + {{16{ir[15]}}, ir[15:0]};
            case (ir[31:26])
                6'h0a: regs[ir[20:16]] = ea;
                6'h08: regs[ir[20:16]] = mem[ea[9:0]];
                6'h09: mem[ea[9:0]] = regs[ir[20:16]];
                6'h03: regs[ir[15:11]] = regs[ir[25:21]] | regs[ir[20:16]];
                6'h3f: return;
                default: ;
            endcase
        end
    endfunction

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] = bd_data;
        if (bd_clr) for (int k = 0; k < NR; k++) regs[k] = 32'hdead0000 | k;
        if (mem_we) begin mem[mem_addr] = mem_wdata; we_log[8'(n_we)] = mem_addr; n_we++; end
        if (mem_re) begin rdata_q <= mem[mem_addr]; rd_log[8'(n_rd)] = mem_addr; n_rd++; end
        if (reg_we) begin regs[reg_addr] = reg_wdata; n_regwe++; end
        if (core_pc_clr) begin
            run_cyc <= 0;
            if (exec_en) exec_prog();
        end else if (core_run) run_cyc <= run_cyc + 1;
        if ((int'(mem_we) + int'(mem_re) + int'(reg_we)) > 1 ||
            ((mem_we || mem_re || reg_we) && core_run)) n_excl++;
        if (core_run) n_run++;
        if (in_ready) n_inrdy++;
        if (out_valid) n_outv++;
        if (out_valid && out_ready) begin out_log[8'(n_out)] = out_data; n_out++; end
        if (hold_pend && (!out_valid || out_data !== hold_data)) n_stab++;
        hold_pend = out_valid && !out_ready;
        hold_data = out_data;
    end

    logic [31:0] prog [0:7] = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                                32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
    int n_chk = 0, n_pass = 0;

    task automatic do_start(input int ll, input int db, input int dl);
        @(negedge clk);
        start = 1'b1; load_len = AW'(ll); dump_base = AW'(db); dump_len = AW'(dl);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic backdoor(input int a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = 10'(a); bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic feed(input int n);
        int got = 0;
        bit rdy = 1'b0;
        for (int c = 0; c < 400 && got < n; c++) begin
            @(negedge clk);
            if (in_valid && rdy) got++;
            rdy      = in_ready;
            in_valid = (got < n) && ($urandom_range(3) != 0);
            in_data  = prog[got % 8];
        end
        in_valid = 1'b0;
        n_chk++;
        if (got !== n) $display("FAIL feed: accepted %0d words, want %0d", got, n);
        else n_pass++;
    endtask

    task automatic wait_done(input int bound, input bit rand_rdy);
        int c;
        for (c = 0; c < bound; c++) begin
            @(negedge clk);
            if (done) break;
            out_ready = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
        end
        out_ready = 1'b1;
        if (c == bound) begin
            n_chk++;
            $display("FAIL wait_done: done not seen within %0d cycles, want done=1", bound);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (all_outs !== '0) $display("FAIL reset_outs: got %h want 0", all_outs); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (all_outs !== '0) $display("FAIL idle_outs: got %h want 0", all_outs); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        int b = n_we;
        halt_en = 1'b1; halt_n = 3; exec_en = 1'b0;
        do_start(8, 0, 0);
        feed(3);
        n_chk++; if (n_we - b !== 3) $display("FAIL mid_load_writes: got %0d want 3", n_we - b); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL mid_load_busy: got %b want 1", busy); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (core_run !== 1'b0 || busy !== 1'b0) $display("FAIL async_abort: run=%b busy=%b want 0", core_run, busy); else n_pass++;
        @(negedge clk);
        n_chk++; if (all_outs !== '0) $display("FAIL mid_reset_outs: got %h want 0", all_outs); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_program();
        int bw, bo;
        backdoor(120, 32'd85);
        exec_en = 1'b1; halt_en = 1'b1; halt_n = 10;
        bw = n_we; bo = n_out;
        do_start(8, 120, 2);
        feed(8);
        wait_done(300, 1'b0);
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (we_log[8'(bw + i)] !== 10'(i)) $display("FAIL load_addr%0d: got %0d want %0d", i, we_log[8'(bw + i)], i);
            else n_pass++;
        end
        n_chk++; if (n_out - bo !== 2) $display("FAIL prog_count: got %0d want 2", n_out - bo); else n_pass++;
        n_chk++; if (out_log[8'(bo)] !== 32'd85) $display("FAIL prog_out0: got %0d want 85", out_log[8'(bo)]); else n_pass++;
        n_chk++; if (out_log[8'(bo + 1)] !== 32'd130) $display("FAIL prog_out1: got %0d want 130", out_log[8'(bo + 1)]); else n_pass++;
        n_chk++; if (done !== 1'b1 || timed_out !== 1'b0) $display("FAIL prog_status: done=%b to=%b want 1/0", done, timed_out); else n_pass++;
        exec_en = 1'b0;
    endtask

    task automatic test_reginit();
        int br = n_regwe, bn = n_run;
        @(negedge clk); bd_clr = 1'b1; @(negedge clk); bd_clr = 1'b0;
        halt_en = 1'b1; halt_n = 0;
        do_start(0, 0, 0);
        wait_done(200, 1'b0);
        n_chk++; if (n_regwe - br !== NR) $display("FAIL reg_we_pulses: got %0d want %0d", n_regwe - br, NR); else n_pass++;
        for (int k = 0; k < NR; k++) begin
            n_chk++;
            if (regs[k] !== 32'(k)) $display("FAIL reg%0d: got %h want %h", k, regs[k], k); else n_pass++;
        end
        n_chk++; if (n_run - bn !== 1) $display("FAIL halted_on_entry: run %0d cycles want 1", n_run - bn); else n_pass++;
    endtask

    task automatic test_timeout();
        int bn = n_run;
        halt_en = 1'b0;
        do_start(0, 0, 0);
        wait_done(200, 1'b0);
        n_chk++; if (n_run - bn !== TO) $display("FAIL timeout_run: got %0d cycles want %0d", n_run - bn, TO); else n_pass++;
        n_chk++; if (done !== 1'b1 || timed_out !== 1'b1) $display("FAIL timeout_status: done=%b to=%b want 1/1", done, timed_out); else n_pass++;
    endtask

    task automatic test_dump_wrap();
        logic [31:0] v [0:3];
        int br, bo, bs;
        for (int i = 0; i < 4; i++) begin
            v[i] = $urandom;
            backdoor((1022 + i) % 1024, v[i]);
        end
        halt_en = 1'b1; halt_n = 2;
        br = n_rd; bo = n_out; bs = n_stab;
        do_start(0, 1022, 4);
        n_chk++; if (done !== 1'b0 || timed_out !== 1'b0) $display("FAIL restart_clear: done=%b to=%b want 0/0", done, timed_out); else n_pass++;
        wait_done(600, 1'b1);
        n_chk++; if (n_rd - br !== 4 || n_out - bo !== 4) $display("FAIL wrap_counts: reads %0d outs %0d want 4/4", n_rd - br, n_out - bo); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (rd_log[8'(br + i)] !== 10'((1022 + i) % 1024)) $display("FAIL wrap_addr%0d: got %0d want %0d", i, rd_log[8'(br + i)], (1022 + i) % 1024);
            else n_pass++;
            n_chk++;
            if (out_log[8'(bo + i)] !== v[i]) $display("FAIL wrap_data%0d: got %h want %h", i, out_log[8'(bo + i)], v[i]);
            else n_pass++;
        end
        n_chk++; if (n_stab - bs !== 0) $display("FAIL hold_stable: %0d unstable cycles want 0", n_stab - bs); else n_pass++;
    endtask

    task automatic test_ignore_start();
        int bi = n_inrdy, bo = n_outv, bn = n_run, c;
        halt_en = 1'b1; halt_n = 6;
        do_start(0, 0, 0);
        for (c = 0; c < 100 && !core_run; c++) @(negedge clk);
        start = 1'b1; load_len = 10'd5; dump_len = 10'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, 1'b0);
        n_chk++; if (n_inrdy - bi !== 0) $display("FAIL no_in_ready: got %0d cycles want 0", n_inrdy - bi); else n_pass++;
        n_chk++; if (n_outv - bo !== 0) $display("FAIL no_out_valid: got %0d cycles want 0", n_outv - bo); else n_pass++;
        n_chk++; if (n_run - bn !== 7) $display("FAIL ignore_run: got %0d cycles want 7", n_run - bn); else n_pass++;
        n_chk++; if (done !== 1'b1 || timed_out !== 1'b0) $display("FAIL ignore_status: done=%b to=%b want 1/0", done, timed_out); else n_pass++;
        n_chk++; if (n_excl !== 0) $display("FAIL strobe_exclusive: %0d violations want 0", n_excl); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_load();
        test_program();
        test_reginit();
        test_timeout();
        test_dump_wrap();
        test_ignore_start();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end
endmodule
